// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the data-memory arbiter: ownership states and
// memory write codes, plus the helper that turns a requester command into a safe write strobe.
package mips_bus_pkg;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_WORD = 2'b01,
        WE_BYTE = 2'b10,
        WE_RSVD = 2'b11
    } mem_we_e;

    // A write reaches memory only with a live request; the reserved code reads.
    function automatic logic [1:0] we_gate(input logic req, input logic [1:0] we);
        if (req && (we == WE_WORD || we == WE_BYTE)) begin
            return we;
        end
        return WE_NONE;
    endfunction

endpackage

// File: rtl/arb_cnt.sv
// Arbiter counters: a loadable down-counter for the remaining DMA burst
// beats and a saturating up-counter for how long the DMA has been blocked.
module arb_cnt #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_dec,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic             o_last,
    output logic             o_wait_thr
);

    localparam int                BEAT_W   = LEN_W + 1;
    localparam logic [BEAT_W-1:0] FULL_LEN = BEAT_W'(2**LEN_W);
    localparam logic [7:0]        WAIT_MAX = 8'(MAX_WAIT);
    localparam logic [7:0]        WAIT_THR = 8'(MAX_WAIT - 1);

    logic [BEAT_W-1:0] r_beats;
    logic [7:0]        r_wait;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs at the same edge regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beats <= '0;
        end else if (i_load) begin
            r_beats <= (i_len == '0) ? FULL_LEN : {1'b0, i_len};
        end else if (i_dec && r_beats != '0) begin
            r_beats <= r_beats - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (i_clr) begin
            r_wait <= '0;
        end else if (i_inc && r_wait != WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign o_last     = (r_beats == BEAT_W'(1));
    assign o_wait_thr = (r_wait == WAIT_THR);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the data memory: the CPU MEM stage owns the port by
// default, the DMA engine takes it for bursts when idle or after a bounded wait.
module dm_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8,
    parameter int LEN_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [1:0]        c_boff,
    input  logic [1:0]        c_we,
    input  logic [31:0]       c_wd,
    output logic              c_ack,
    output logic              c_stall,
    input  logic              d_req,
    input  logic [LEN_W-1:0]  d_len,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_boff,
    input  logic [1:0]        d_we,
    input  logic [31:0]       d_wd,
    output logic              d_ack,
    output logic              d_busy,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [1:0]        dm_boff,
    output logic [1:0]        dm_we,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       w_load;
    logic       w_dec;
    logic       w_inc;
    logic       w_clr;
    logic       w_last;
    logic       w_wait_thr;

    arb_cnt #(
        .LEN_W    (LEN_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_len      (d_len),
        .i_dec      (w_dec),
        .i_inc      (w_inc),
        .i_clr      (w_clr),
        .o_last     (w_last),
        .o_wait_thr (w_wait_thr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OWN_C;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_inc        = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            OWN_C: begin
                if (d_req && (!c_req || w_wait_thr)) begin
                    w_next_state = OWN_D;
                    w_load       = 1'b1;
                    w_clr        = 1'b1;
                end else if (d_req) begin
                    w_inc = 1'b1;
                end else begin
                    w_clr = 1'b1;
                end
            end
            OWN_D: begin
                w_dec = d_req;
                if (!d_req || w_last) begin
                    w_next_state = OWN_C;
                end
            end
            default: w_next_state = OWN_C;
        endcase
    end

    always_comb begin
        dm_addr = c_addr;
        dm_boff = c_boff;
        dm_wd   = c_wd;
        dm_we   = we_gate(c_req, c_we);
        c_ack   = c_req;
        c_stall = 1'b0;
        d_ack   = 1'b0;
        d_busy  = 1'b0;
        if (r_state == OWN_D) begin
            dm_addr = d_addr;
            dm_boff = d_boff;
            dm_wd   = d_wd;
            dm_we   = we_gate(d_req, d_we);
            c_ack   = 1'b0;
            c_stall = c_req;
            d_ack   = d_req;
            d_busy  = 1'b1;
        end
        // Held reset blocks every access even though the C port stays muxed in.
        if (!rst) begin
            dm_we   = WE_NONE;
            c_ack   = 1'b0;
            c_stall = 1'b0;
            d_ack   = 1'b0;
        end
    end

    assign rdata = dm_rd;

endmodule
